instr_fetch_decode: RTL and testbench

//  Front end of the move-machine core. Fetches 32-bit instruction words from instruction memory at the
//  PC supplied by the register file, decodes them into its src/dst/lw/imm/j/br/bq_blt controls and

---
 rtl/instr_fetch_decode_pkg.sv | 48 ++++
 rtl/instr_fetch_decode_if.sv | 17 +
 rtl/instr_fetch_decode_decode.sv | 46 ++++
 rtl/instr_fetch_decode.sv | 139 +++++++++++++
 tb/tb_instr_fetch_decode.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the move-machine instruction front end.
//   - opcode encodings and instruction field bit positions
//   - FSM state encoding for the fetch sequencer
//   - result-register index range (read-only regs in the register file map)
//   - decoded control bundle passed from the decoder to the fetch FSM
package instr_fetch_decode_pkg;

   localparam logic [1:0] OP_MOVE = 2'b00;
   localparam logic [1:0] OP_LW   = 2'b01;
   localparam logic [1:0] OP_J    = 2'b10;
   localparam logic [1:0] OP_BR   = 2'b11;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 30;
   localparam int BQ_BIT = 29;
   localparam int SRC_HI = 25;
   localparam int SRC_LO = 21;
   localparam int DST_HI = 20;
   localparam int DST_LO = 16;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   // Register file indices 1..9 are computed results and cannot be written by a move.
   localparam logic [4:0] RES_REG_FIRST = 5'd1;
   localparam logic [4:0] RES_REG_LAST  = 5'd9;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_ISSUE = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   typedef struct packed {
      logic [4:0]  src;
      logic [4:0]  dst;
      logic [15:0] imm;
      logic        lw;
      logic        j;
      logic        br;
      logic        bq_blt;
   } ctrl_t;

   function automatic logic is_result_reg(input logic [4:0] idx);
      return (idx >= RES_REG_FIRST) && (idx <= RES_REG_LAST);
   endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Instruction memory read bus.
//   mem_req  : read request, held until acknowledged
//   mem_addr : read address
//   mem_ack  : read data valid this cycle
//   mem_data : 32-bit instruction word
// master = fetch unit, slave = instruction memory.
interface instr_fetch_decode_if #(
   parameter int ADDR_W = 16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_data;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/instr_fetch_decode_decode.sv
// instr_decode: pure combinational instruction word -> control fields.
//   i_word    : 32-bit instruction word
//   o_ctrl    : decoded src/dst/imm/lw/j/br/bq_blt bundle (unused fields zero)
//   o_illegal : move targeting a read-only result register
module instr_decode
   import instr_fetch_decode_pkg::*;
(
   input  logic [31:0] i_word,
   output ctrl_t       o_ctrl,
   output logic        o_illegal
);

   logic [1:0] op;
   logic       ignored_unused;

   assign op = i_word[OP_HI:OP_LO];
   // Bits [28:26] carry no meaning in this instruction set.
   assign ignored_unused = ^i_word[28:26];

   always_comb begin
      o_ctrl    = '0;
      o_illegal = 1'b0;
      unique case (op)
         OP_MOVE: begin
            o_ctrl.src = i_word[SRC_HI:SRC_LO];
            o_ctrl.dst = i_word[DST_HI:DST_LO];
            // dst 0 (PC) is a legal move target; only the result regs are flagged.
            o_illegal  = is_result_reg(i_word[DST_HI:DST_LO]);
         end
         OP_LW: begin
            o_ctrl.lw  = 1'b1;
            o_ctrl.imm = i_word[IMM_HI:IMM_LO];
         end
         OP_J: begin
            o_ctrl.j   = 1'b1;
            o_ctrl.imm = i_word[IMM_HI:IMM_LO];
         end
         default: begin
            o_ctrl.br     = 1'b1;
            o_ctrl.bq_blt = i_word[BQ_BIT];
            o_ctrl.imm    = i_word[IMM_HI:IMM_LO];
         end
      endcase
   end

endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetch/decode/issue front end of the move-machine core.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_pc           : current PC from the register file
//   i_run          : enable fetch; 0 pauses at the next instruction boundary
//   mem            : instruction memory read bus (master side)
//   o_issue        : one-cycle strobe, decoded fields valid (NOP otherwise)
//   o_src/o_dst/o_imm/o_lw/o_j/o_br/o_bq_blt : decoded controls
//   o_illegal, o_halted, o_fault : sticky status flags, cleared only by reset
// Sequence per instruction: IDLE/WAIT -> REQ -> ISSUE -> WAIT.
module instr_fetch_decode
   import instr_fetch_decode_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [ADDR_W-1:0]     i_pc,
   input  logic                  i_run,
   instr_fetch_decode_if.master  mem,
   output logic                  o_issue,
   output logic [4:0]            o_src,
   output logic [4:0]            o_dst,
   output logic [15:0]           o_imm,
   output logic                  o_lw,
   output logic                  o_j,
   output logic                  o_br,
   output logic                  o_bq_blt,
   output logic                  o_illegal,
   output logic                  o_halted,
   output logic                  o_fault
);

   // Last counter value at which a missing ack still leaves the request alive.
   localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

   state_t            state_q;
   logic              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        cnt_q;
   logic              issue_q;
   ctrl_t             ctrl_q;
   logic              illegal_q;
   logic              halted_q;
   logic              fault_q;
   logic              jself_q;

   ctrl_t             ctrl_d;
   logic              illegal_d;

   instr_decode u_decode (
      .i_word    (mem.mem_data),
      .o_ctrl    (ctrl_d),
      .o_illegal (illegal_d)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         req_q     <= 1'b0;
         addr_q    <= '0;
         cnt_q     <= '0;
         issue_q   <= 1'b0;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
         halted_q  <= 1'b0;
         fault_q   <= 1'b0;
         jself_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (i_run && !halted_q && !fault_q) begin
                  addr_q  <= i_pc;
                  req_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               // Ack is checked first so an ack on the last allowed cycle beats the timeout.
               if (mem.mem_ack) begin
                  req_q   <= 1'b0;
                  cnt_q   <= '0;
                  issue_q <= 1'b1;
                  ctrl_q  <= ctrl_d;
                  if (illegal_d) begin
                     illegal_q <= 1'b1;
                  end
                  jself_q <= ctrl_d.j && (addr_q == ADDR_W'(ctrl_d.imm));
                  state_q <= S_ISSUE;
               end else if (cnt_q == TO_LAST) begin
                  req_q   <= 1'b0;
                  cnt_q   <= '0;
                  fault_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            S_ISSUE: begin
               // Outputs fall back to a NOP the cycle after the strobe.
               issue_q <= 1'b0;
               ctrl_q  <= '0;
               if (jself_q) begin
                  halted_q <= 1'b1;
               end
               jself_q <= 1'b0;
               state_q <= S_WAIT;
            end
            default: begin
               // Bubble cycle: the register file has now advanced i_pc.
               if (i_run && !halted_q) begin
                  addr_q  <= i_pc;
                  req_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_REQ;
               end else begin
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign mem.mem_req  = req_q;
   assign mem.mem_addr = addr_q;
   assign o_issue      = issue_q;
   assign o_src        = ctrl_q.src;
   assign o_dst        = ctrl_q.dst;
   assign o_imm        = ctrl_q.imm;
   assign o_lw         = ctrl_q.lw;
   assign o_j          = ctrl_q.j;
   assign o_br         = ctrl_q.br;
   assign o_bq_blt     = ctrl_q.bq_blt;
   assign o_illegal    = illegal_q;
   assign o_halted     = halted_q;
   assign o_fault      = fault_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed testbench for instr_fetch_decode. Inputs change and outputs are
// sampled on the falling clock edge, half a period away from the active edge.
module tb_instr_fetch_decode;

   logic        clk;
   logic        rst_n;
   logic [15:0] pc;
   logic        run;
   logic        issue;
   logic [4:0]  src;
   logic [4:0]  dst;
   logic [15:0] imm;
   logic        lw;
   logic        j;
   logic        br;
   logic        bq;
   logic        illegal;
   logic        halted;
   logic        fault;

   int n_checks = 0;
   int n_fail   = 0;

   instr_fetch_decode_if #(.ADDR_W(16)) mem_bus ();

   instr_fetch_decode #(.ADDR_W(16), .TIMEOUT(15)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_pc      (pc),
      .i_run     (run),
      .mem       (mem_bus),
      .o_issue   (issue),
      .o_src     (src),
      .o_dst     (dst),
      .o_imm     (imm),
      .o_lw      (lw),
      .o_j       (j),
      .o_br      (br),
      .o_bq_blt  (bq),
      .o_illegal (illegal),
      .o_halted  (halted),
      .o_fault   (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   // Advance at least one cycle, then until a request shows or the budget expires.
   task automatic wait_req(input int max, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_bus.mem_req && n < max);
   endtask

   // Present a word with ack for one cycle; returns at the following falling edge.
   task automatic ack_now(input logic [31:0] word);
      $display("fetch addr=%04h word=%08h", mem_bus.mem_addr, word);
      mem_bus.mem_ack  = 1'b1;
      mem_bus.mem_data = word;
      @(negedge clk);
      mem_bus.mem_ack  = 1'b0;
      mem_bus.mem_data = 32'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      run   = 1'b0;
      pc    = 16'h0;
      mem_bus.mem_ack  = 1'b0;
      mem_bus.mem_data = 32'h0;
      repeat (2) step();
      n_checks++;
      if ({mem_bus.mem_req, issue, lw, j, br, bq, illegal, halted, fault} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 000000000",
                  {mem_bus.mem_req, issue, lw, j, br, bq, illegal, halted, fault});
      end
      n_checks++;
      if ({mem_bus.mem_addr, src, dst, imm} !== 42'h0) begin
         n_fail++;
         $display("FAIL reset_fields: got %h expected 0", {mem_bus.mem_addr, src, dst, imm});
      end
   endtask

   task automatic test_load_imm();
      int n;
      rst_n = 1'b1;
      run   = 1'b1;
      pc    = 16'h0;
      wait_req(4, n);
      n_checks++;
      if (!(mem_bus.mem_req === 1'b1 && n == 1)) begin
         n_fail++;
         $display("FAIL lw_req_start: got req=%b after %0d cycles expected req=1 after 1", mem_bus.mem_req, n);
      end
      n_checks++;
      if (mem_bus.mem_addr !== 16'h0) begin
         n_fail++;
         $display("FAIL lw_addr: got %h expected 0000", mem_bus.mem_addr);
      end
      ack_now(32'h4000_1234);
      n_checks++;
      if ({issue, lw, imm} !== {1'b1, 1'b1, 16'h1234}) begin
         n_fail++;
         $display("FAIL lw_issue: got issue=%b lw=%b imm=%h expected 1 1 1234", issue, lw, imm);
      end
      n_checks++;
      if ({src, dst, j, br, bq, illegal, halted, fault} !== 16'h0) begin
         n_fail++;
         $display("FAIL lw_others: got %h expected 0", {src, dst, j, br, bq, illegal, halted, fault});
      end
      pc = 16'h1;
      step();
      n_checks++;
      if ({issue, lw, imm, mem_bus.mem_req} !== 19'h0) begin
         n_fail++;
         $display("FAIL lw_nop_after: got issue=%b lw=%b imm=%h req=%b expected all 0", issue, lw, imm, mem_bus.mem_req);
      end
      wait_req(4, n);
      n_checks++;
      if (!(mem_bus.mem_req === 1'b1 && mem_bus.mem_addr === 16'h1 && n == 1)) begin
         n_fail++;
         $display("FAIL lw_next_req: got req=%b addr=%h after %0d expected req=1 addr=0001 after 1",
                  mem_bus.mem_req, mem_bus.mem_addr, n);
      end
   endtask

   task automatic test_move();
      int n;
      ack_now(32'h0076_0000);
      n_checks++;
      if ({issue, src, dst, lw, j, br, imm, illegal} !== {1'b1, 5'd3, 5'd22, 3'b000, 16'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL move_legal: got issue=%b src=%0d dst=%0d lw/j/br=%b%b%b imm=%h illegal=%b expected 1 3 22 000 0000 0",
                  issue, src, dst, lw, j, br, imm, illegal);
      end
      pc = 16'h2;
      step();
      wait_req(4, n);
      ack_now(32'h00A4_0000);
      n_checks++;
      if ({issue, src, dst, illegal} !== {1'b1, 5'd5, 5'd4, 1'b1}) begin
         n_fail++;
         $display("FAIL move_illegal: got issue=%b src=%0d dst=%0d illegal=%b expected 1 5 4 1", issue, src, dst, illegal);
      end
      pc = 16'h3;
      step();
      wait_req(4, n);
      ack_now(32'h4000_0001);
      n_checks++;
      if ({issue, lw, imm, illegal} !== {1'b1, 1'b1, 16'h0001, 1'b1}) begin
         n_fail++;
         $display("FAIL illegal_sticky: got issue=%b lw=%b imm=%h illegal=%b expected 1 1 0001 1", issue, lw, imm, illegal);
      end
   endtask

   task automatic test_branch();
      int n;
      pc = 16'h4;
      step();
      wait_req(4, n);
      ack_now(32'hE000_0010);
      n_checks++;
      if ({issue, br, bq, imm, lw, j, src, dst} !== {3'b111, 16'h0010, 2'b00, 10'h0}) begin
         n_fail++;
         $display("FAIL branch_eq: got issue=%b br=%b bq=%b imm=%h lw=%b j=%b src=%0d dst=%0d expected 1 1 1 0010 0 0 0 0",
                  issue, br, bq, imm, lw, j, src, dst);
      end
      pc = 16'h5;
      step();
      n_checks++;
      if ({issue, br, bq, mem_bus.mem_req} !== 4'b0000) begin
         n_fail++;
         $display("FAIL branch_bubble: got issue=%b br=%b bq=%b req=%b expected 0 0 0 0", issue, br, bq, mem_bus.mem_req);
      end
      wait_req(4, n);
      n_checks++;
      if (!(mem_bus.mem_req === 1'b1 && n == 1 && mem_bus.mem_addr === 16'h5)) begin
         n_fail++;
         $display("FAIL back_to_back_req: got req=%b addr=%h after %0d expected req=1 addr=0005 after 1",
                  mem_bus.mem_req, mem_bus.mem_addr, n);
      end
      ack_now(32'hC000_0010);
      n_checks++;
      if ({issue, br, bq, imm} !== {1'b1, 1'b1, 1'b0, 16'h0010}) begin
         n_fail++;
         $display("FAIL branch_mt: got issue=%b br=%b bq=%b imm=%h expected 1 1 0 0010", issue, br, bq, imm);
      end
   endtask

   task automatic test_run_pause();
      int n;
      int hi;
      pc = 16'h6;
      step();
      wait_req(4, n);
      run = 1'b0;
      ack_now(32'h4000_0055);
      n_checks++;
      if ({issue, lw, imm} !== {1'b1, 1'b1, 16'h0055}) begin
         n_fail++;
         $display("FAIL pause_issue: got issue=%b lw=%b imm=%h expected 1 1 0055", issue, lw, imm);
      end
      hi = 0;
      repeat (6) begin
         step();
         if (mem_bus.mem_req || issue) hi++;
      end
      n_checks++;
      if (hi != 0) begin
         n_fail++;
         $display("FAIL pause_idle: got %0d active cycles expected 0", hi);
      end
      pc  = 16'h7;
      run = 1'b1;
      wait_req(4, n);
      n_checks++;
      if (!(mem_bus.mem_req === 1'b1 && n == 1 && mem_bus.mem_addr === 16'h7)) begin
         n_fail++;
         $display("FAIL resume_req: got req=%b addr=%h after %0d expected req=1 addr=0007 after 1",
                  mem_bus.mem_req, mem_bus.mem_addr, n);
      end
   endtask

   task automatic test_timeout();
      int n;
      int hi;
      int seen;
      // Request to 0x0007 is already outstanding and never acknowledged.
      hi   = 1;
      seen = 0;
      while (mem_bus.mem_req && hi < 40) begin
         step();
         if (issue) seen++;
         if (mem_bus.mem_req) hi++;
      end
      n_checks++;
      if (hi != 15) begin
         n_fail++;
         $display("FAIL timeout_req_cycles: got %0d expected 15", hi);
      end
      n_checks++;
      if ({fault, mem_bus.mem_req} !== 2'b10 || seen != 0) begin
         n_fail++;
         $display("FAIL timeout_fault: got fault=%b req=%b issues=%0d expected 1 0 0", fault, mem_bus.mem_req, seen);
      end
      hi = 0;
      repeat (5) begin
         step();
         if (mem_bus.mem_req) hi++;
      end
      n_checks++;
      if (hi != 0 || fault !== 1'b1) begin
         n_fail++;
         $display("FAIL fault_blocks_fetch: got req_cycles=%0d fault=%b expected 0 1", hi, fault);
      end
      // Ack on the final allowed cycle must win over the timeout.
      rst_n = 1'b0;
      step();
      n_checks++;
      if ({fault, illegal} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_clears_sticky: got fault=%b illegal=%b expected 0 0", fault, illegal);
      end
      rst_n = 1'b1;
      pc    = 16'h8;
      wait_req(4, n);
      repeat (14) step();
      n_checks++;
      if (mem_bus.mem_req !== 1'b1 || fault !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_edge_req: got req=%b fault=%b expected 1 0", mem_bus.mem_req, fault);
      end
      ack_now(32'h4000_00AA);
      n_checks++;
      if ({issue, imm, fault} !== {1'b1, 16'h00AA, 1'b0}) begin
         n_fail++;
         $display("FAIL timeout_edge_ack: got issue=%b imm=%h fault=%b expected 1 00aa 0", issue, imm, fault);
      end
   endtask

   task automatic test_jump_self();
      int n;
      int hi;
      pc = 16'h0010;
      step();
      wait_req(4, n);
      ack_now(32'h8000_0020);
      n_checks++;
      if ({issue, j, imm} !== {1'b1, 1'b1, 16'h0020}) begin
         n_fail++;
         $display("FAIL jump_other: got issue=%b j=%b imm=%h expected 1 1 0020", issue, j, imm);
      end
      pc = 16'h0020;
      step();
      n_checks++;
      if (halted !== 1'b0) begin
         n_fail++;
         $display("FAIL jump_other_no_halt: got halted=%b expected 0", halted);
      end
      wait_req(4, n);
      n_checks++;
      if (!(mem_bus.mem_req === 1'b1 && mem_bus.mem_addr === 16'h0020)) begin
         n_fail++;
         $display("FAIL jump_self_req: got req=%b addr=%h expected 1 0020", mem_bus.mem_req, mem_bus.mem_addr);
      end
      ack_now(32'h8000_0020);
      n_checks++;
      if ({issue, j, imm, halted} !== {1'b1, 1'b1, 16'h0020, 1'b0}) begin
         n_fail++;
         $display("FAIL jump_self_issue: got issue=%b j=%b imm=%h halted=%b expected 1 1 0020 0", issue, j, imm, halted);
      end
      step();
      n_checks++;
      if (halted !== 1'b1) begin
         n_fail++;
         $display("FAIL jump_self_halted: got halted=%b expected 1", halted);
      end
      hi = 0;
      repeat (10) begin
         step();
         if (mem_bus.mem_req || issue) hi++;
      end
      n_checks++;
      if (hi != 0 || halted !== 1'b1) begin
         n_fail++;
         $display("FAIL halted_parks: got active_cycles=%0d halted=%b expected 0 1", hi, halted);
      end
   endtask

   task automatic test_reset_mid_req();
      int n;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      pc    = 16'h0007;
      wait_req(4, n);
      n_checks++;
      if (!(mem_bus.mem_req === 1'b1 && halted === 1'b0)) begin
         n_fail++;
         $display("FAIL restart_after_halt: got req=%b halted=%b expected 1 0", mem_bus.mem_req, halted);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({mem_bus.mem_req, mem_bus.mem_addr} !== 17'h0) begin
         n_fail++;
         $display("FAIL async_req_drop: got req=%b addr=%h expected 0 0000", mem_bus.mem_req, mem_bus.mem_addr);
      end
      mem_bus.mem_ack  = 1'b1;
      mem_bus.mem_data = 32'h4000_0077;
      step();
      rst_n = 1'b1;
      step();
      mem_bus.mem_ack  = 1'b0;
      mem_bus.mem_data = 32'h0;
      n_checks++;
      if ({issue, mem_bus.mem_req, mem_bus.mem_addr} !== {1'b0, 1'b1, 16'h0007}) begin
         n_fail++;
         $display("FAIL late_ack_ignored: got issue=%b req=%b addr=%h expected 0 1 0007", issue, mem_bus.mem_req, mem_bus.mem_addr);
      end
      step();
      ack_now(32'h4000_0077);
      n_checks++;
      if ({issue, lw, imm} !== {1'b1, 1'b1, 16'h0077}) begin
         n_fail++;
         $display("FAIL refetch_issue: got issue=%b lw=%b imm=%h expected 1 1 0077", issue, lw, imm);
      end
   endtask

   initial begin
      test_reset();
      test_load_imm();
      test_move();
      test_branch();
      test_run_pause();
      test_timeout();
      test_jump_self();
      test_reset_mid_req();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish before 100000ns");
      $fatal(1, "watchdog expired");
   end

endmodule
